// File: rtl/validready2noc_injection_arbiter.sv
// Packet-level round-robin arbiter sharing one valid/ready sink; a grant is held from first beat to last.
// Build option VALIDREADY2NOC_ARB_OUTPUT_REG_EN adds a 2-entry skid buffer on the master side.
module validready2noc_injection_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            s_valid_i,
  output logic [NUM_PORTS-1:0]            s_ready_o,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_PORTS-1:0]            s_last_i,
  output logic                            m_valid_o,
  input  logic                            m_ready_i,
  output logic [DATA_WIDTH-1:0]           m_data_o,
  output logic                            m_last_o,
  output logic [SRC_WIDTH-1:0]            m_src_o,
  output logic                            busy_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q;
  logic [SRC_WIDTH-1:0]  gnt_q, rr_q, rr_d, pick_d;
  logic                  pick_vld_d, busy_q;
  logic                  locked, g_valid, g_last, g_ready, acc, acc_last;
  logic [DATA_WIDTH-1:0] g_data;

  // Scan from lowest to highest priority so the last hit (closest to rr_q) wins.
  always_comb begin
    int idx;
    pick_d     = rr_q;
    pick_vld_d = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = (int'(rr_q) + i) % NUM_PORTS;
      if (s_valid_i[idx]) begin
        pick_d     = SRC_WIDTH'(idx);
        pick_vld_d = 1'b1;
      end
    end
  end

  assign rr_d     = (int'(gnt_q) == NUM_PORTS - 1) ? '0 : gnt_q + 1'b1;
  assign locked   = (state_q == LOCKED);
  assign g_valid  = s_valid_i[gnt_q];
  assign g_last   = s_last_i[gnt_q];
  assign g_data   = s_data_i[gnt_q*DATA_WIDTH +: DATA_WIDTH];
  assign acc      = locked & g_valid & g_ready;
  assign acc_last = acc & g_last;

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      s_ready_o[k] = locked && (int'(gnt_q) == k) && g_ready;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            gnt_q   <= pick_d;
            state_q <= LOCKED;
            busy_q  <= 1'b1;
          end
        end
        LOCKED: begin
          if (acc_last) begin
            rr_q    <= rr_d;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VALIDREADY2NOC_ARB_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] buf_dat_q [2];
  logic [SRC_WIDTH-1:0]  buf_src_q [2];
  logic [1:0]            buf_last_q;
  logic                  wr_q, rd_q, pop;
  logic [1:0]            cnt_q;

  // Upstream ready depends only on occupancy, cutting the m_ready_i -> s_ready_o path.
  assign g_ready = (cnt_q != 2'd2);
  assign pop     = (cnt_q != 2'd0) && m_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
      buf_last_q <= 2'b00;
    end else begin
      if (acc) begin
        buf_dat_q[wr_q]  <= g_data;
        buf_src_q[wr_q]  <= gnt_q;
        buf_last_q[wr_q] <= g_last;
        wr_q             <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, acc} - {1'b0, pop};
    end
  end

  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = m_valid_o ? buf_dat_q[rd_q] : '0;
  assign m_last_o  = m_valid_o & buf_last_q[rd_q];
  assign m_src_o   = m_valid_o ? buf_src_q[rd_q] : gnt_q;
  assign busy_o    = busy_q | m_valid_o;
`else
  assign g_ready   = m_ready_i;
  assign m_valid_o = locked & g_valid;
  assign m_data_o  = locked ? g_data : '0;
  assign m_last_o  = locked & g_last;
  assign m_src_o   = gnt_q;
  assign busy_o    = busy_q;
`endif

endmodule

// File: doc/validready2noc_injection_arbiter.md
# validready2noc_injection_arbiter

Packet-level round-robin arbiter that shares the single valid/ready input of a `validready2noc_handshake_adapter` instance among `NUM_PORTS` requesters. It sits between the local initiators and the adapter. Each packet is forwarded without interleaving: a grant is locked from the first beat until the beat marked `last` completes. It also reports which source owns the adapter, so the adapter side can tag or route the packet.

## Interface
- `NUM_PORTS`, 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, 32: payload width per beat.
- `SRC_WIDTH`, `$clog2(NUM_PORTS)`: width of the source-index output.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `s_valid_i`  in  NUM_PORTS  per-requester beat valid.
- `s_ready_o`  out  NUM_PORTS  per-requester beat accept.
- `s_data_i`  in  NUM_PORTS*DATA_WIDTH  payloads; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `s_last_i`  in  NUM_PORTS  marks the final beat of a packet.
- `m_valid_o`  out  1  beat valid toward the adapter.
- `m_ready_i`  in  1  adapter accept.
- `m_data_o`  out  DATA_WIDTH  forwarded payload.
- `m_last_o`  out  1  forwarded last flag.
- `m_src_o`  out  SRC_WIDTH  index of the granted requester; stable for the whole packet.
- `busy_o`  out  1  high while a grant is locked.

## Operation
- FSM states:
  - IDLE: no grant held.
  - LOCKED: grant held by `gnt_q`.
- Round-robin pointer `rr_q`:
  - Holds the highest-priority port.
  - Search order is `rr_q`, `rr_q+1`, …, wrapping modulo `NUM_PORTS`.
- IDLE:
  - All `s_ready_o` are 0 and `m_valid_o` is 0.
  - If any `s_valid_i` is high, the first valid port in search order is registered into `gnt_q` and the FSM moves to LOCKED.
- LOCKED (connection is combinational):
  - `m_valid_o` = `s_valid_i[gnt_q]`, `m_data_o` and `m_last_o` are taken from port `gnt_q`.
  - `s_ready_o[gnt_q]` = `m_ready_i`; all other `s_ready_o` are 0.
- End of packet: a handshake with `m_last_o` = 1 moves the FSM to IDLE and sets `rr_q` to `gnt_q+1` modulo `NUM_PORTS`.
- Single-beat packets (`s_last_i` = 1 on the first beat) are legal.
- A requester that drops `s_valid_i` mid-packet keeps the grant; the arbiter waits indefinitely.
- `s_valid_i` or `s_last_i` changing on non-granted ports has no effect on the current packet.
- Reset mid-packet: the grant is abandoned, the FSM goes to IDLE, `rr_q` becomes 0, and any partial packet is the requester's responsibility.
- Reset values:
  - `s_ready_o` = 0, `m_valid_o` = 0, `m_last_o` = 0.
  - `m_data_o` = 0 (gated while IDLE), `m_src_o` = 0, `busy_o` = 0.

## Timing
- Arbitration latency: one cycle from `s_valid_i` rising in IDLE to `m_valid_o` high.
- There is one idle bubble cycle between consecutive packets, so an L-beat packet occupies at least L+1 cycles.
- Throughput inside a packet is one beat per cycle while `s_valid_i[gnt_q]` and `m_ready_i` are both high.
- `m_src_o` and `busy_o` are driven from registers; they update on the cycle that follows entry to LOCKED or exit from it.

## Configuration
- `VALIDREADY2NOC_ARB_OUTPUT_REG_EN` defined:
  - A 2-entry skid buffer is inserted on the master side, holding `m_data_o`, `m_last_o` and `m_src_o`.
  - This adds one cycle of latency and keeps full throughput.
  - There is no combinational path from `m_ready_i` to `s_ready_o`.
  - The FSM leaves LOCKED when the last beat enters the buffer, not when it leaves it.
  - `busy_o` stays high until the buffer is empty.
- Macro undefined: the combinational connection described above; zero added latency.

## Test plan
- Reset check: hold `rst_i` high for 3 cycles with all `s_valid_i` = 4'b1111 -> all outputs stay at their reset values; first grant after release goes to port 0 (`m_src_o` = 0).
- Round-robin fairness: ports 0..3 each continuously offer 2-beat packets -> grant order is 0,1,2,3,0,…; each packet takes 3 cycles with `m_ready_i` = 1.
- Packet lock: port 2 sends a 4-beat packet while port 1 raises valid on beat 2 -> no port-1 beat appears until port 2's `last` handshake; port 1 is granted next.
- Backpressure: toggle `m_ready_i` 1,0,0,1,… during a 5-beat packet from port 3 -> exactly 5 beats with payloads 0x30..0x34 in order, no duplication or loss; `s_ready_o[3]` tracks `m_ready_i`.
- Reset mid-packet: assert `rst_i` on beat 2 of a 4-beat port-1 packet -> next cycle FSM is IDLE and `busy_o` = 0; a new port-3 request is then granted with `m_src_o` = 3.
- Wrap-around: only port 3 and port 0 request, `rr_q` = 3 -> port 3 is served, then port 0, then port 3.
